// File: rtl/udma_hyper_trans_queue.sv
// rtl/udma_hyper_trans_queue.sv - transaction snapshot FIFO between hyperbus register interface and controller
// Optional same-cycle fall-through from an empty, idle queue: define HYPER_TRANSQ_FALLTHROUGH_EN.

module udma_hyper_trans_queue #(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16,
   parameter int MAX_NB_TRAN    = 8,
   parameter int DEPTH          = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,

   input  logic                      trans_valid_i,
   output logic                      trans_ready_o,
   input  logic                      cfg_rw_i,
   input  logic                      cfg_addr_space_i,
   input  logic                      cfg_burst_type_i,
   input  logic [31:0]               cfg_hyper_addr_i,
   input  logic [15:0]               cfg_hyper_intreg_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_rx_size_i,
   input  logic [TRANS_SIZE-1:0]     cfg_tx_size_i,
   input  logic                      cfg_twd_ext_act_i,
   input  logic                      cfg_twd_l2_act_i,
   input  logic [TRANS_SIZE-1:0]     cfg_twd_ext_count_i,
   input  logic [TRANS_SIZE-1:0]     cfg_twd_ext_stride_i,
   input  logic [TRANS_SIZE-1:0]     cfg_twd_l2_count_i,
   input  logic [TRANS_SIZE-1:0]     cfg_twd_l2_stride_i,

   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_rw_o,
   output logic                      out_addr_space_o,
   output logic                      out_burst_type_o,
   output logic [31:0]               out_hyper_addr_o,
   output logic [15:0]               out_hyper_intreg_o,
   output logic [L2_AWIDTH_NOAL-1:0] out_l2_addr_o,
   output logic [TRANS_SIZE-1:0]     out_size_o,
   output logic                      out_twd_ext_act_o,
   output logic                      out_twd_l2_act_o,
   output logic [TRANS_SIZE-1:0]     out_twd_ext_count_o,
   output logic [TRANS_SIZE-1:0]     out_twd_ext_stride_o,
   output logic [TRANS_SIZE-1:0]     out_twd_l2_count_o,
   output logic [TRANS_SIZE-1:0]     out_twd_l2_stride_o,

   input  logic                      trans_done_i,
   output logic [MAX_NB_TRAN:0]      nb_trans_waiting_o,
   output logic                      busy_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int NBW = MAX_NB_TRAN + 1;

   // One stored snapshot; RX/TX address and size are already resolved by rw.
   typedef struct packed {
      logic                      rw;
      logic                      addr_space;
      logic                      burst_type;
      logic [31:0]               hyper_addr;
      logic [15:0]               hyper_intreg;
      logic [L2_AWIDTH_NOAL-1:0] l2_addr;
      logic [TRANS_SIZE-1:0]     size;
      logic                      twd_ext_act;
      logic                      twd_l2_act;
      logic [TRANS_SIZE-1:0]     twd_ext_count;
      logic [TRANS_SIZE-1:0]     twd_ext_stride;
      logic [TRANS_SIZE-1:0]     twd_l2_count;
      logic [TRANS_SIZE-1:0]     twd_l2_stride;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            active;

   entry_t          in_entry;
   entry_t          head_entry;
   entry_t          out_entry;
   logic            fifo_nonempty;
   logic            fifo_full;
   logic            bypass;
   logic            handshake;
   logic            push;
   logic            pop;

   // Build the snapshot from the register interface, selecting RX or TX side now.
   always_comb begin
      in_entry                = '0;
      in_entry.rw             = cfg_rw_i;
      in_entry.addr_space     = cfg_addr_space_i;
      in_entry.burst_type     = cfg_burst_type_i;
      in_entry.hyper_addr     = cfg_hyper_addr_i;
      in_entry.hyper_intreg   = cfg_hyper_intreg_i;
      in_entry.l2_addr        = cfg_rw_i ? cfg_rx_startaddr_i : cfg_tx_startaddr_i;
      in_entry.size           = cfg_rw_i ? cfg_rx_size_i : cfg_tx_size_i;
      in_entry.twd_ext_act    = cfg_twd_ext_act_i;
      in_entry.twd_l2_act     = cfg_twd_l2_act_i;
      in_entry.twd_ext_count  = cfg_twd_ext_count_i;
      in_entry.twd_ext_stride = cfg_twd_ext_stride_i;
      in_entry.twd_l2_count   = cfg_twd_l2_count_i;
      in_entry.twd_l2_stride  = cfg_twd_l2_stride_i;
   end

   assign head_entry    = mem[rd_ptr];
   assign fifo_nonempty = (count != '0);
   assign fifo_full     = (count == CW'(DEPTH));

`ifdef HYPER_TRANSQ_FALLTHROUGH_EN
   // Empty and idle: the incoming snapshot is offered directly in the same cycle.
   assign bypass = ~fifo_nonempty & ~active & trans_valid_i;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid_o = (fifo_nonempty & ~active) | bypass;
   assign out_entry   = bypass ? in_entry : head_entry;
   assign handshake   = out_valid_o & out_ready_i;

   // A bypassed entry that is accepted immediately never touches storage.
   assign pop  = handshake & ~bypass;
   assign push = trans_valid_i & ~fifo_full & ~(bypass & out_ready_i);

   assign trans_ready_o      = ~fifo_full;
   assign busy_o             = fifo_nonempty | active;
   assign nb_trans_waiting_o = NBW'(count);

   assign out_rw_o             = out_entry.rw;
   assign out_addr_space_o     = out_entry.addr_space;
   assign out_burst_type_o     = out_entry.burst_type;
   assign out_hyper_addr_o     = out_entry.hyper_addr;
   assign out_hyper_intreg_o   = out_entry.hyper_intreg;
   assign out_l2_addr_o        = out_entry.l2_addr;
   assign out_size_o           = out_entry.size;
   assign out_twd_ext_act_o    = out_entry.twd_ext_act;
   assign out_twd_l2_act_o     = out_entry.twd_l2_act;
   assign out_twd_ext_count_o  = out_entry.twd_ext_count;
   assign out_twd_ext_stride_o = out_entry.twd_ext_stride;
   assign out_twd_l2_count_o   = out_entry.twd_l2_count;
   assign out_twd_l2_stride_o  = out_entry.twd_l2_stride;

   // Snapshot storage is written on push only and deliberately has no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Pointers wrap naturally; occupancy tracks push/pop, unchanged when both occur.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // One transaction outstanding: set on acceptance, cleared by the completion pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active <= 1'b0;
      end else if (handshake) begin
         active <= 1'b1;
      end else if (trans_done_i) begin
         active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_udma_hyper_trans_queue.sv
// tb/tb_udma_hyper_trans_queue.sv - scoreboard bench for udma_hyper_trans_queue

module tb_udma_hyper_trans_queue;

   localparam int AW    = 12;
   localparam int TS    = 16;
   localparam int NBT   = 8;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic          rw;
      logic          aspace;
      logic          burst;
      logic [31:0]   haddr;
      logic [15:0]   intreg;
      logic [AW-1:0] rx_sa;
      logic [AW-1:0] tx_sa;
      logic [TS-1:0] rx_sz;
      logic [TS-1:0] tx_sz;
      logic          ext_act;
      logic          l2_act;
      logic [TS-1:0] ext_cnt;
      logic [TS-1:0] ext_str;
      logic [TS-1:0] l2_cnt;
      logic [TS-1:0] l2_str;
   } cfg_t;

   typedef struct packed {
      logic          rw;
      logic          aspace;
      logic          burst;
      logic [31:0]   haddr;
      logic [15:0]   intreg;
      logic [AW-1:0] l2_addr;
      logic [TS-1:0] size;
      logic          ext_act;
      logic          l2_act;
      logic [TS-1:0] ext_cnt;
      logic [TS-1:0] ext_str;
      logic [TS-1:0] l2_cnt;
      logic [TS-1:0] l2_str;
   } exp_t;

   typedef struct packed {
      logic         ready;
      logic         valid;
      logic         busy;
      logic [NBT:0] nb;
   } stat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trans_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          trans_done = 1'b0;
   cfg_t          cur = '0;

   logic          trans_ready;
   logic          out_valid;
   logic          out_rw, out_aspace, out_burst;
   logic [31:0]   out_haddr;
   logic [15:0]   out_intreg;
   logic [AW-1:0] out_l2;
   logic [TS-1:0] out_size;
   logic          out_ext_act, out_l2_act;
   logic [TS-1:0] out_ext_cnt, out_ext_str, out_l2_cnt, out_l2_str;
   logic [NBT:0]  nb_waiting;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: entries still in the FIFO and whether one is outstanding.
   exp_t  mq[$];
   bit    mact = 1'b0;
   // Scoreboard queues filled by the driver, drained by the monitor.
   exp_t  exp_q[$];
   stat_t stat_q[$];

   always #5 clk = ~clk;

   udma_hyper_trans_queue #(
      .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .MAX_NB_TRAN(NBT), .DEPTH(DEPTH)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .trans_valid_i        (trans_valid),
      .trans_ready_o        (trans_ready),
      .cfg_rw_i             (cur.rw),
      .cfg_addr_space_i     (cur.aspace),
      .cfg_burst_type_i     (cur.burst),
      .cfg_hyper_addr_i     (cur.haddr),
      .cfg_hyper_intreg_i   (cur.intreg),
      .cfg_rx_startaddr_i   (cur.rx_sa),
      .cfg_tx_startaddr_i   (cur.tx_sa),
      .cfg_rx_size_i        (cur.rx_sz),
      .cfg_tx_size_i        (cur.tx_sz),
      .cfg_twd_ext_act_i    (cur.ext_act),
      .cfg_twd_l2_act_i     (cur.l2_act),
      .cfg_twd_ext_count_i  (cur.ext_cnt),
      .cfg_twd_ext_stride_i (cur.ext_str),
      .cfg_twd_l2_count_i   (cur.l2_cnt),
      .cfg_twd_l2_stride_i  (cur.l2_str),
      .out_valid_o          (out_valid),
      .out_ready_i          (out_ready),
      .out_rw_o             (out_rw),
      .out_addr_space_o     (out_aspace),
      .out_burst_type_o     (out_burst),
      .out_hyper_addr_o     (out_haddr),
      .out_hyper_intreg_o   (out_intreg),
      .out_l2_addr_o        (out_l2),
      .out_size_o           (out_size),
      .out_twd_ext_act_o    (out_ext_act),
      .out_twd_l2_act_o     (out_l2_act),
      .out_twd_ext_count_o  (out_ext_cnt),
      .out_twd_ext_stride_o (out_ext_str),
      .out_twd_l2_count_o   (out_l2_cnt),
      .out_twd_l2_stride_o  (out_l2_str),
      .trans_done_i         (trans_done),
      .nb_trans_waiting_o   (nb_waiting),
      .busy_o               (busy)
   );

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic exp_t sel(input cfg_t c);
      exp_t e;
      e.rw      = c.rw;
      e.aspace  = c.aspace;
      e.burst   = c.burst;
      e.haddr   = c.haddr;
      e.intreg  = c.intreg;
      e.l2_addr = c.rw ? c.rx_sa : c.tx_sa;
      e.size    = c.rw ? c.rx_sz : c.tx_sz;
      e.ext_act = c.ext_act;
      e.l2_act  = c.l2_act;
      e.ext_cnt = c.ext_cnt;
      e.ext_str = c.ext_str;
      e.l2_cnt  = c.l2_cnt;
      e.l2_str  = c.l2_str;
      return e;
   endfunction

   function automatic cfg_t rnd_cfg();
      cfg_t c;
      c.rw      = 1'($urandom);
      c.aspace  = 1'($urandom);
      c.burst   = 1'($urandom);
      c.haddr   = $urandom;
      c.intreg  = 16'($urandom);
      c.rx_sa   = AW'($urandom);
      c.tx_sa   = AW'($urandom);
      c.rx_sz   = TS'($urandom);
      c.tx_sz   = TS'($urandom);
      c.ext_act = 1'($urandom);
      c.l2_act  = 1'($urandom);
      c.ext_cnt = TS'($urandom);
      c.ext_str = TS'($urandom);
      c.l2_cnt  = TS'($urandom);
      c.l2_str  = TS'($urandom);
      return c;
   endfunction

   // Drive one cycle of stimulus and advance the reference model to match.
   task automatic cyc(input bit v, input bit r, input bit d, input cfg_t c);
      stat_t s;
      bit    full, mvalid, byp, pop, push_ok;
      @(posedge clk);
      #1;
      trans_valid = v;
      out_ready   = r;
      trans_done  = d;
      cur         = c;
      full   = (mq.size() == DEPTH);
      mvalid = (mq.size() != 0) && !mact;
      byp    = 1'b0;
`ifdef HYPER_TRANSQ_FALLTHROUGH_EN
      byp = (mq.size() == 0) && !mact && v;
      if (byp) mvalid = 1'b1;
`endif
      s.ready = !full;
      s.valid = mvalid;
      s.busy  = (mq.size() != 0) || mact;
      s.nb    = (NBT + 1)'(mq.size());
      stat_q.push_back(s);
      pop     = mvalid && r;
      push_ok = v && !full;
      if (pop && !byp) void'(mq.pop_front());
      if (push_ok) begin
         exp_q.push_back(sel(c));
         if (!(byp && r)) mq.push_back(sel(c));
      end
      if (d) mact = 1'b0;
      if (pop) mact = 1'b1;
   endtask

   // Monitor: compare status every cycle and the offered head against the scoreboard.
   always @(negedge clk) begin
      stat_t s;
      exp_t  got;
      if (stat_q.size() != 0) begin
         s = stat_q.pop_front();
         chk("trans_ready", 256'(trans_ready), 256'(s.ready));
         chk("out_valid", 256'(out_valid), 256'(s.valid));
         chk("busy", 256'(busy), 256'(s.busy));
         chk("nb_waiting", 256'(nb_waiting), 256'(s.nb));
      end
      if (rst_n && out_valid) begin
         got = '{out_rw, out_aspace, out_burst, out_haddr, out_intreg, out_l2, out_size,
                 out_ext_act, out_l2_act, out_ext_cnt, out_ext_str, out_l2_cnt, out_l2_str};
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 256'(1), 256'(0));
         end else begin
            chk("head_entry", 256'(got), 256'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH + 4; i++) cyc(0, 1, 1, rnd_cfg());
      cyc(0, 0, 1, rnd_cfg());
   endtask

   task automatic reset_check(input string tag);
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      trans_valid = 1'b0;
      out_ready   = 1'b0;
      trans_done  = 1'b0;
      #1;
      chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
      chk({tag, "_busy"}, 256'(busy), 256'(0));
      chk({tag, "_nb_waiting"}, 256'(nb_waiting), 256'(0));
      chk({tag, "_trans_ready"}, 256'(trans_ready), 256'(1));
      mq.delete();
      exp_q.delete();
      stat_q.delete();
      mact = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      cfg_t c;
      reset_check("reset");

      // Single RX push with distinctive address/size.
      c = rnd_cfg();
      c.rw = 1'b1; c.haddr = 32'h100; c.rx_sz = 16'd64;
      cyc(1, 0, 0, c);
      cyc(0, 0, 0, rnd_cfg());
      cyc(0, 1, 0, rnd_cfg());
      cyc(0, 0, 1, rnd_cfg());

      // Five pushes into a four-deep queue; the fifth is dropped.
      for (int i = 0; i < 5; i++) begin
         c = rnd_cfg();
         c.haddr = 32'(4 * i);
         cyc(1, 0, 0, c);
      end
      cyc(0, 0, 0, rnd_cfg());
      // Push and pop while full: push rejected, count 4 -> 3.
      c = rnd_cfg(); c.haddr = 32'hDEAD;
      cyc(1, 1, 0, c);
      // Entry outstanding for ten cycles with ready held high: nothing offered.
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, rnd_cfg());
      cyc(0, 1, 1, rnd_cfg());
      cyc(0, 1, 0, rnd_cfg());
      cyc(0, 0, 1, rnd_cfg());
      // Count is 2: push and pop together keeps it at 2 across the pointer wrap.
      c = rnd_cfg(); c.haddr = 32'h40;
      cyc(1, 1, 0, c);
      cyc(0, 0, 1, rnd_cfg());
      c = rnd_cfg(); c.haddr = 32'h44;
      cyc(1, 1, 0, c);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         bit v, r, d;
         v = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 35);
         d = mact ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 10);
         cyc(v, r, d, rnd_cfg());
      end
      drain();

      // Reset with three queued entries and one outstanding.
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, rnd_cfg());
      cyc(0, 1, 0, rnd_cfg());
      cyc(0, 0, 0, rnd_cfg());
      reset_check("midreset");

      for (int i = 0; i < 200; i++) begin
         cyc(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < 25), rnd_cfg());
      end
      drain();
      @(negedge clk);
      #1;
      chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/udma_hyper_trans_queue.md
Name: udma_hyper_trans_queue

Overview:
- Sits directly downstream of the hyperbus channel register interface.
- Captures a snapshot of the transaction configuration on every trans_valid pulse and stores it in a DEPTH-entry FIFO.
- Issues snapshots one at a time to the hyperbus transaction controller over a valid/ready handshake.
- Reports trans_ready, waiting count and busy back to the register interface for its STATUS register and cfg_ready.

Parameters:
- L2_AWIDTH_NOAL, 12: L2 address width.
- TRANS_SIZE, 16: transfer size, 2D count and 2D stride width.
- MAX_NB_TRAN, 8: waiting-count port is MAX_NB_TRAN+1 bits.
- DEPTH, 4: FIFO entries; power of two, 2 <= DEPTH <= 2**MAX_NB_TRAN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- trans_valid_i  in  1  single-cycle push request from the register interface
- trans_ready_o  out  1  FIFO can accept a push
- cfg_rw_i  in  1  1=read (RX), 0=write (TX)
- cfg_addr_space_i  in  1  0=memory, 1=register space
- cfg_burst_type_i  in  1  0=wrapped, 1=linear
- cfg_hyper_addr_i  in  32  device address
- cfg_hyper_intreg_i  in  16  register-space write data
- cfg_rx_startaddr_i, cfg_tx_startaddr_i  in  L2_AWIDTH_NOAL  L2 addresses
- cfg_rx_size_i, cfg_tx_size_i  in  TRANS_SIZE  byte sizes
- cfg_twd_ext_act_i, cfg_twd_l2_act_i  in  1  2D enables
- cfg_twd_ext_count_i, cfg_twd_ext_stride_i, cfg_twd_l2_count_i, cfg_twd_l2_stride_i  in  TRANS_SIZE  2D parameters
- out_valid_o  out  1  head entry is offered to the controller
- out_ready_i  in  1  controller accepts the head entry
- out_rw_o, out_addr_space_o, out_burst_type_o  out  1  head fields
- out_hyper_addr_o  out  32
- out_hyper_intreg_o  out  16
- out_l2_addr_o  out  L2_AWIDTH_NOAL  rx_startaddr if rw=1, else tx_startaddr
- out_size_o  out  TRANS_SIZE  rx_size if rw=1, else tx_size
- out_twd_ext_act_o, out_twd_l2_act_o  out  1
- out_twd_ext_count_o, out_twd_ext_stride_o, out_twd_l2_count_o, out_twd_l2_stride_o  out  TRANS_SIZE
- trans_done_i  in  1  single-cycle pulse when the active transaction completes
- nb_trans_waiting_o  out  MAX_NB_TRAN+1  number of FIFO entries, zero-extended
- busy_o  out  1  FIFO non-empty or a transaction is active

Behaviour:
- Storage and pointers:
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - The RX/TX field selection by rw happens at push time; each entry stores only the selected L2 address and size.
- Push:
  - trans_ready_o = (count != DEPTH), computed from registered state.
  - Push occurs when trans_valid_i & trans_ready_o. The entry is written at the clock edge and appears in the count one cycle later.
  - trans_valid_i while full: the request is dropped with no state change. trans_ready_o is low that cycle.
- Active flag:
  - Set when out_valid_o & out_ready_i.
  - Cleared on trans_done_i.
  - trans_done_i while not active is ignored.
- Pop:
  - out_valid_o = (count != 0) & ~active. Only one transaction is outstanding at a time.
  - Pop occurs on out_valid_o & out_ready_i: the read pointer advances and active is set.
  - out_* fields are driven combinationally from the head entry. When out_valid_o=0 they are don't-care, but must be stable while out_valid_o=1.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full and pop in the same cycle: the push is still rejected, because ready is derived from the pre-edge count.
  - trans_done_i and out_ready_i in the same cycle: out_valid_o is 0, so no pop occurs.
- Status outputs:
  - busy_o = (count != 0) | active.
  - nb_trans_waiting_o = count, excluding the active transaction.
- Reset (asynchronous, including mid-operation):
  - Pointers, count and active go to 0.
  - Resulting outputs: trans_ready_o=1, out_valid_o=0, busy_o=0, nb_trans_waiting_o=0.
  - FIFO storage is not reset; out_* data is don't-care after reset.

Optional Feature:
- Macro: HYPER_TRANSQ_FALLTHROUGH_EN.
- Defined:
  - When count==0, active==0 and trans_valid_i=1, the input snapshot is presented on out_* in the same cycle with out_valid_o=1.
  - If out_ready_i=1 that cycle, the entry bypasses storage: count unchanged, active set.
  - If out_ready_i=0, the entry is pushed normally.
- Undefined:
  - Minimum latency from trans_valid_i to out_valid_o is 1 cycle.

Test Plan:
- Reset, then one push (rw=1, hyper_addr=0x100, rx_size=64) -> next cycle out_valid_o=1, out_l2_addr_o=rx_startaddr, out_size_o=64, nb_trans_waiting_o=1, busy_o=1.
- 5 pushes with out_ready_i=0 and DEPTH=4 -> trans_ready_o=0 after the 4th; 5th dropped; nb_trans_waiting_o=4; pop order returns hyper_addr 0x0,0x4,0x8,0xC.
- Pop entry A, hold trans_done_i low for 10 cycles -> out_valid_o=0 throughout, busy_o=1; trans_done_i pulse -> entry B offered next cycle.
- Full FIFO, push and pop in the same cycle -> push rejected, count 4->3; non-full FIFO at count 2, push and pop together -> count stays 2, order preserved across pointer wrap.
- Assert rst_ni low with 3 queued entries and one active -> immediately out_valid_o=0, busy_o=0, nb_trans_waiting_o=0, trans_ready_o=1.
- HYPER_TRANSQ_FALLTHROUGH_EN defined, empty FIFO, trans_valid_i with out_ready_i=1 -> same-cycle out_valid_o=1, count remains 0, busy_o=1 next cycle.
